root_digit_squarer: RTL and testbench

- Digit-serial squarer; the inverse partner of the digit-serial square-root unit.
- Consumes a root digit stream (digits {0,1,2}, MSB-first, weight 2^-i) and rebuilds Y incrementally. Accumulates Y^2 on the fly, then emits the square as 2-bit digits MSB-first.
- Used to check root results in-system and to generate root-unit stimulus from known roots.

---
 rtl/root_pkg.sv | 24 ++
 rtl/sq_digit_step.sv | 62 ++++++
 rtl/root_digit_squarer.sv | 152 +++++++++++++++
 tb/tb_root_digit_squarer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/root_pkg.sv
// root_pkg: definitions shared by the digit-serial square-root unit and its
// squarer partner. Holds the root-digit encodings, the control state enum and
// the default operand widths.
package root_pkg;

   // Default number of root digits per operation.
   localparam int unsigned ROOT_N = 4;
   // Integer root width and square width for the default digit count.
   localparam int unsigned Y_W    = ROOT_N + 1;
   localparam int unsigned S_W    = 2 * ROOT_N + 2;

   // Root digit encodings (MSB-first, weight 2^-i).
   localparam logic [1:0] DIG_ZERO = 2'b00;
   localparam logic [1:0] DIG_ONE  = 2'b01;
   localparam logic [1:0] DIG_TWO  = 2'b10;
   localparam logic [1:0] DIG_BAD  = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      EMIT
   } root_state_e;

endpackage

// File: rtl/sq_digit_step.sv
// sq_digit_step: one combinational step of the digit-serial squarer.
// Appends root digit d to Y and updates the running square S so that S == Y*Y
// holds after every step:
//   Y' = 2Y + d
//   S' = 4S + 4*Y*d + d*d   (old Y)
// Y*d is a select/shift, so no multiplier is inferred. An illegal digit (11)
// is treated as 0 and flagged on bad_o.
// Ports:
//   y_i   [N:0]      current partial root
//   s_i   [2N+1:0]   current partial square
//   d_i   [1:0]      incoming root digit
//   y_o   [N:0]      updated partial root
//   s_o   [2N+1:0]   updated partial square
//   bad_o            d_i was the illegal encoding
module sq_digit_step
   import root_pkg::*;
#(
   parameter int unsigned N = ROOT_N
) (
   input  logic [N:0]     y_i,
   input  logic [2*N+1:0] s_i,
   input  logic [1:0]     d_i,
   output logic [N:0]     y_o,
   output logic [2*N+1:0] s_o,
   output logic           bad_o
);

   localparam int unsigned YW = N + 1;
   localparam int unsigned SW = 2 * N + 2;

   logic [1:0]    d_eff;
   logic [SW-1:0] y_ext;
   logic [SW-1:0] yd;
   logic [SW-1:0] dd;

   assign bad_o = (d_i == DIG_BAD);
   assign d_eff = bad_o ? DIG_ZERO : d_i;
   assign y_ext = SW'(y_i);

   always_comb begin
      yd = '0;
      dd = '0;
      case (d_eff)
         DIG_ONE: begin
            yd = y_ext;
            dd = SW'(1);
         end
         DIG_TWO: begin
            yd = y_ext << 1;
            dd = SW'(4);
         end
         default: begin
            yd = '0;
            dd = '0;
         end
      endcase
   end

   assign y_o = {y_i[YW-2:0], 1'b0} + YW'(d_eff);
   assign s_o = (s_i << 2) + (yd << 2) + dd;

endmodule

// File: rtl/root_digit_squarer.sv
// root_digit_squarer: digit-serial squarer. Takes N root digits {0,1,2}
// MSB-first, builds Y and Y^2 on the fly, then emits Y^2 as N+1 two-bit
// digits MSB-first with a valid/ready handshake.
// Ports:
//   i_clk, i_Reset     clock, asynchronous active-high reset
//   i_start            begin an operation (only taken in IDLE)
//   i_valid, i_d       input root digit stream; o_ready accepts it
//   o_x, o_valid       output square digit stream; i_ready accepts it
//   o_last             final output digit
//   o_sq               full square, stable during EMIT
//   o_error            sticky illegal-digit flag for the current operation
//   o_busy             high in ACCUM or EMIT
module root_digit_squarer
   import root_pkg::*;
#(
   parameter int unsigned N = ROOT_N
) (
   input  logic           i_clk,
   input  logic           i_Reset,
   input  logic           i_start,
   input  logic           i_valid,
   input  logic [1:0]     i_d,
   output logic           o_ready,
   output logic [1:0]     o_x,
   output logic           o_valid,
   input  logic           i_ready,
   output logic           o_last,
   output logic [2*N+1:0] o_sq,
   output logic           o_error,
   output logic           o_busy
);

   localparam int unsigned YW = N + 1;
   localparam int unsigned SW = 2 * N + 2;
   localparam int unsigned CW = $clog2(N + 2);

   localparam logic [CW-1:0] CntLast = CW'(N - 1);
   localparam logic [CW-1:0] KLast   = CW'(N);

   root_state_e   state_q;
   logic [YW-1:0] y_q;
   logic [SW-1:0] s_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] k_q;
   logic          ready_q;
   logic          valid_q;
   logic          last_q;
   logic          error_q;
   logic          busy_q;
   logic [1:0]    x_q;

   logic [YW-1:0] y_d;
   logic [SW-1:0] s_d;
   logic          bad_d;
   logic [CW-1:0] k_nxt;

   // Output digit k is S[2N+1-2k : 2N-2k].
   function automatic logic [1:0] sq_digit(input logic [SW-1:0] s, input logic [CW-1:0] k);
      logic [SW-1:0] t;
      t = s >> (2 * (N - 32'(k)));
      return t[1:0];
   endfunction

   sq_digit_step #(
      .N (N)
   ) u_step (
      .y_i   (y_q),
      .s_i   (s_q),
      .d_i   (i_d),
      .y_o   (y_d),
      .s_o   (s_d),
      .bad_o (bad_d)
   );

   assign k_nxt = k_q + 1'b1;

   always_ff @(posedge i_clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q <= IDLE;
         y_q     <= '0;
         s_q     <= '0;
         count_q <= '0;
         k_q     <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         error_q <= 1'b0;
         busy_q  <= 1'b0;
         x_q     <= DIG_ZERO;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_start) begin
                  y_q     <= '0;
                  s_q     <= '0;
                  count_q <= '0;
                  k_q     <= '0;
                  error_q <= 1'b0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= ACCUM;
               end
            end
            ACCUM: begin
               if (i_valid && ready_q) begin
                  y_q     <= y_d;
                  s_q     <= s_d;
                  count_q <= count_q + 1'b1;
                  if (bad_d) begin
                     error_q <= 1'b1;
                  end
                  if (count_q == CntLast) begin
                     // First output digit comes straight from the final update so
                     // o_valid rises one cycle after the last acceptance.
                     state_q <= EMIT;
                     ready_q <= 1'b0;
                     valid_q <= 1'b1;
                     k_q     <= '0;
                     x_q     <= sq_digit(s_d, '0);
                     last_q  <= (KLast == '0);
                  end
               end
            end
            EMIT: begin
               if (valid_q && i_ready) begin
                  if (k_q == KLast) begin
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     busy_q  <= 1'b0;
                     x_q     <= DIG_ZERO;
                     state_q <= IDLE;
                  end else begin
                     k_q    <= k_nxt;
                     x_q    <= sq_digit(s_q, k_nxt);
                     last_q <= (k_nxt == KLast);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_ready = ready_q;
   assign o_valid = valid_q;
   assign o_x     = x_q;
   assign o_last  = last_q;
   assign o_sq    = s_q;
   assign o_error = error_q;
   assign o_busy  = busy_q;

endmodule

// File: tb/tb_root_digit_squarer.sv
// Directed bench for root_digit_squarer (N=4). Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_root_digit_squarer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       valid;
   logic [1:0] d;
   logic       ready_o;
   logic [1:0] x;
   logic       x_valid;
   logic       x_ready;
   logic       last;
   logic [9:0] sq;
   logic       err;
   logic       busy;

   int total;
   int bad;

   root_digit_squarer #(
      .N (4)
   ) dut (
      .i_clk   (clk),
      .i_Reset (rst),
      .i_start (start),
      .i_valid (valid),
      .i_d     (d),
      .o_ready (ready_o),
      .o_x     (x),
      .o_valid (x_valid),
      .i_ready (x_ready),
      .o_last  (last),
      .o_sq    (sq),
      .o_error (err),
      .o_busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Start and feed four digits (digs[7:6] first), gap idle cycles before each.
   task automatic feed(input logic [7:0] digs, input int gap);
      logic [1:0] dig;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ready_after_start", int'(ready_o), 1);
      check("busy_after_start", int'(busy), 1);
      check("err_cleared", int'(err), 0);
      for (int i = 0; i < 4; i++) begin
         repeat (gap) tick();
         dig   = digs[7-2*i -: 2];
         valid = 1'b1;
         d     = dig;
         tick();
         valid = 1'b0;
         d     = 2'b00;
      end
   endtask

   // Drain five output digits (xs[9:8] first); stall i_ready before index stall_k.
   task automatic drain(input string nm, input logic [9:0] xs, input int exp_sq, input int exp_err,
                        input int stall_k, input int stall_n);
      logic [1:0] ex;
      int         n;
      for (int k = 0; k < 5; k++) begin
         n = 0;
         while (!x_valid && n < 8) begin
            tick();
            n++;
         end
         check({nm, "_valid"}, int'(x_valid), 1);
         ex = xs[9-2*k -: 2];
         if (k == stall_k) begin
            x_ready = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               tick();
               check({nm, "_stall_x"}, int'(x), int'(ex));
               check({nm, "_stall_valid"}, int'(x_valid), 1);
            end
         end
         check({nm, "_x"}, int'(x), int'(ex));
         check({nm, "_last"}, int'(last), (k == 4) ? 1 : 0);
         check({nm, "_sq"}, int'(sq), exp_sq);
         check({nm, "_err"}, int'(err), exp_err);
         x_ready = 1'b1;
         tick();
         x_ready = 1'b0;
      end
      check({nm, "_done_valid"}, int'(x_valid), 0);
      check({nm, "_done_busy"}, int'(busy), 0);
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      rst     = 1'b1;
      start   = 1'b0;
      valid   = 1'b0;
      d       = 2'b00;
      x_ready = 1'b0;
      #2;
      check("rst_ready", int'(ready_o), 0);
      check("rst_valid", int'(x_valid), 0);
      check("rst_last", int'(last), 0);
      check("rst_err", int'(err), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_x", int'(x), 0);
      check("rst_sq", int'(sq), 0);
      tick();
      rst = 1'b0;
      tick();

      // Valid digit while idle with no start must be ignored.
      valid = 1'b1;
      d     = 2'b01;
      tick();
      valid = 1'b0;
      check("idle_ignore_busy", int'(busy), 0);
      check("idle_ignore_sq", int'(sq), 0);

      // Y=11 -> 121
      feed(8'b01_00_01_01, 0);
      drain("y11", 10'b00_01_11_10_01, 121, 0, -1, 0);

      // Y=30 -> 900
      feed(8'b10_10_10_10, 0);
      drain("y30", 10'b11_10_00_01_00, 900, 0, -1, 0);

      // Y=0 -> 0
      feed(8'b00_00_00_00, 0);
      drain("y0", 10'b00_00_00_00_00, 0, 0, -1, 0);

      // Illegal digit treated as 0: Y=8 -> 64, error sticky
      feed(8'b01_11_00_00, 0);
      drain("ybad", 10'b00_01_00_00_00, 64, 1, -1, 0);
      check("err_sticky_idle", int'(err), 1);

      // Gapped input plus output stall on k=2 -> same as Y=11
      feed(8'b01_00_01_01, 2);
      drain("gap", 10'b00_01_11_10_01, 121, 0, 2, 3);

      // Reset during EMIT at k=2
      feed(8'b01_00_01_01, 0);
      for (int k = 0; k < 2; k++) begin
         x_ready = 1'b1;
         tick();
      end
      x_ready = 1'b0;
      check("pre_rst_valid", int'(x_valid), 1);
      rst = 1'b1;
      #1;
      check("async_rst_valid", int'(x_valid), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_sq", int'(sq), 0);
      tick();
      rst = 1'b0;
      tick();
      feed(8'b01_00_00_00, 0);
      drain("post_rst", 10'b00_01_00_00_00, 64, 0, -1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
